// File: rtl/turbo_deitl.sv
// Turbo block de-interleaver: stores a block in interleaved order at pi(k)=(k*67) mod N and reads it back in natural order.
// Latency: 1 cycle from each read issue to dout_vld. There is no backpressure; din_vld arriving in READY or DRAIN is dropped and sets the sticky ovf flag.
module turbo_deitl (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [5:0] link_id,
    input  logic       din,
    input  logic       din_vld,
    input  logic       request,
    output logic       dout,
    output logic       dout_vld,
    output logic       ready,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [13:0] n_len_q, n_len_d;
    logic [13:0] count_q, count_d;
    logic [13:0] waddr_q, waddr_d;
    logic [13:0] raddr_q, raddr_d;
    logic        dout_q, dout_d;
    logic        dout_vld_q, dout_vld_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;

    logic        wr_en;
    logic [12:0] wr_addr;
    logic        rd_en;
    logic [6:0]  blk_units;
    logic [13:0] step_sum;

    logic        mem [0:8191];

    always_comb begin
        state_d    = state_q;
        n_len_d    = n_len_q;
        count_d    = count_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        wr_en      = 1'b0;
        wr_addr    = 13'd0;
        rd_en      = 1'b0;
        blk_units  = {1'b0, link_id} + 7'd1;
        step_sum   = waddr_q + 14'd67;

        case (state_q)
            IDLE: begin
                if (din_vld) begin
                    n_len_d = {blk_units, 7'b0};
                    wr_en   = 1'b1;
                    wr_addr = 13'd0;
                    count_d = 14'd1;
                    waddr_d = 14'd67;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (din_vld) begin
                    wr_en   = 1'b1;
                    wr_addr = waddr_q[12:0];
                    count_d = count_q + 14'd1;
                    // waddr < N and 67 < N, so one conditional subtract keeps it in range
                    waddr_d = (step_sum >= n_len_q) ? (step_sum - n_len_q) : step_sum;
                    if (count_d == n_len_q) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (request) begin
                    raddr_d = 14'd0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rd_en = 1'b1;
                if (raddr_q == n_len_q - 14'd1) begin
                    raddr_d = 14'd0;
                    state_d = IDLE;
                end else begin
                    raddr_d = raddr_q + 14'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        dout_d     = rd_en ? mem[raddr_q[12:0]] : dout_q;
        dout_vld_d = rd_en;
        ovf_d      = ovf_q | (din_vld & ((state_q == READY) | (state_q == DRAIN)));
        ready_d    = (state_d == READY);
        busy_d     = (state_d == FILL) | (state_d == DRAIN);
    end

    // RAM has no reset; an aborted block can never reach READY, so stale data is never read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            n_len_q    <= 14'd128;
            count_q    <= 14'd0;
            waddr_q    <= 14'd0;
            raddr_q    <= 14'd0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_len_q    <= n_len_d;
            count_q    <= count_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_turbo_deitl.sv
// Scoreboard bench for turbo_deitl: expected natural-order bits are queued at request time,
// and an independent monitor pops and compares them on every dout_vld.
module tb_turbo_deitl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [5:0] link_id = 6'd0;
    logic       din = 1'b0;
    logic       din_vld = 1'b0;
    logic       request = 1'b0;
    logic       dout;
    logic       dout_vld;
    logic       ready;
    logic       busy;
    logic       ovf;

    turbo_deitl dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .link_id  (link_id),
        .din      (din),
        .din_vld  (din_vld),
        .request  (request),
        .dout     (dout),
        .dout_vld (dout_vld),
        .ready    (ready),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    logic pat [0:8191];
    logic exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: every dout_vld must match the head of the expected queue
    always @(negedge clk) begin
        if (n_rst && dout_vld) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_dout_vld: got dout_vld=1, required 0 (no block requested)");
            end else begin
                logic e;
                e = exp_q.pop_front();
                n_cmp++;
                if (dout !== e) begin
                    n_bad++;
                    $display("FAIL dout_bit%0d: got %0b, required %0b", n_out, dout, e);
                end
                n_out++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: b[n] = n[0]^n[3]; mode 1: random payload
    task automatic fill_pat(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            logic [13:0] iv;
            iv = i[13:0];
            pat[i] = (mode == 0) ? (iv[0] ^ iv[3]) : logic'($urandom_range(1, 0));
        end
    endtask

    // Feeds bits in interleaved order: position k carries natural bit (k*67) mod N
    task automatic send_block(input int link, input int nbits, input int gapmax, input int req_at);
        int n;
        n = (link + 1) * 128;
        for (int k = 0; k < nbits; k++) begin
            if (gapmax > 0) begin
                din_vld = 1'b0;
                repeat ($urandom_range(gapmax, 0)) tick();
            end
            din_vld = 1'b1;
            din     = pat[(k * 67) % n];
            link_id = (k == 0) ? link[5:0] : ~link[5:0];
            request = (k == req_at);
            tick();
            request = 1'b0;
        end
        din_vld = 1'b0;
    endtask

    task automatic issue_request(input int n);
        request = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(pat[i]);
        tick();
        request = 1'b0;
    endtask

    task automatic wait_empty(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got %0d bits outstanding, required 0", nm, exp_q.size());
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_dout", {31'd0, dout}, 0);
        chk("rst_dout_vld", {31'd0, dout_vld}, 0);
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        tick();
        n_rst = 1'b1;
        tick();

        // Request in IDLE is ignored
        request = 1'b1;
        tick();
        request = 1'b0;
        tick();
        chk("idle_req_busy", {31'd0, busy}, 0);

        // N=128 pattern block, with a stray request mid-FILL
        fill_pat(0, 128);
        send_block(0, 128, 0, 60);
        chk("t1_ready", {31'd0, ready}, 1);
        chk("t1_busy", {31'd0, busy}, 0);
        issue_request(128);
        chk("t1_drain_busy", {31'd0, busy}, 1);
        chk("t1_drain_ready", {31'd0, ready}, 0);
        wait_empty("t1", 200);
        chk("t1_done_busy", {31'd0, busy}, 0);
        chk("t1_ovf", {31'd0, ovf}, 0);

        // din_vld held high through READY and DRAIN
        fill_pat(1, 128);
        send_block(0, 128, 1, -1);
        din_vld = 1'b1;
        din     = 1'b1;
        repeat (3) tick();
        chk("t3_ready_hold", {31'd0, ready}, 1);
        chk("t3_ovf_ready", {31'd0, ovf}, 1);
        issue_request(128);
        repeat (127) begin
            din = ~din;
            tick();
        end
        din_vld = 1'b0;
        wait_empty("t3", 200);
        tick();
        chk("t3_ovf_sticky", {31'd0, ovf}, 1);
        chk("t3_idle_busy", {31'd0, busy}, 0);

        // Reset after 50 bits of FILL, then an N=384 block
        fill_pat(1, 384);
        send_block(2, 50, 0, -1);
        chk("t4_busy_fill", {31'd0, busy}, 1);
        n_rst = 1'b0;
        #2;
        chk("t4_rst_busy", {31'd0, busy}, 0);
        chk("t4_rst_ready", {31'd0, ready}, 0);
        chk("t4_rst_ovf", {31'd0, ovf}, 0);
        chk("t4_rst_dout_vld", {31'd0, dout_vld}, 0);
        chk("t4_rst_dout", {31'd0, dout}, 0);
        tick();
        n_rst = 1'b1;
        tick();
        fill_pat(0, 384);
        send_block(2, 384, 0, -1);
        chk("t4_ready", {31'd0, ready}, 1);
        issue_request(384);
        wait_empty("t4", 500);

        // Back-to-back: next block starts in the cycle of the final dout_vld
        fill_pat(0, 128);
        send_block(0, 128, 0, -1);
        issue_request(128);
        repeat (128) tick();
        chk("t5_first_idle_busy", {31'd0, busy}, 0);
        chk("t5_last_vld", {31'd0, dout_vld}, 1);
        fill_pat(1, 256);
        send_block(1, 256, 0, -1);
        chk("t5_ready2", {31'd0, ready}, 1);
        issue_request(256);
        wait_empty("t5", 400);
        chk("t5_ovf", {31'd0, ovf}, 0);

        // N=8192 random payload with random input gaps
        fill_pat(1, 8192);
        send_block(63, 8192, 2, -1);
        chk("t6_ready", {31'd0, ready}, 1);
        issue_request(8192);
        wait_empty("t6", 8300);
        tick();
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_ovf", {31'd0, ovf}, 0);
        chk("t6_out_total", n_out, 128 + 128 + 384 + 128 + 256 + 8192);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
